// File: rtl/encode_arbiter.sv
// Round-robin arbiter and sequencer feeding the router's packet encoder.
// Grants one DFX source at a time, runs the start/ready handshake, and waits for done under a watchdog.
module encode_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_WIDTH       = 2,
  parameter int DATA_DFX_WIDTH = 1034,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*DATA_DFX_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                req_ack,
  output logic [NUM_REQ-1:0]                req_err,
  output logic                              start_encode_pkt,
  output logic [DATA_DFX_WIDTH-1:0]         data_dfx_send,
  input  logic                              ready_encode_pkt,
  input  logic                              encode_done,
  output logic                              busy,
  output logic [ID_WIDTH-1:0]               active_id,
  output logic [15:0]                       frame_cnt
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT_DONE = 2'd2} state_t;

  state_t                    state, state_nxt;
  logic [TCNT_W-1:0]         tcnt, tcnt_nxt;
  logic [ID_WIDTH-1:0]       grant_id, grant_nxt;
  logic [ID_WIDTH-1:0]       last_grant, last_nxt;
  logic [ID_WIDTH-1:0]       winner;
  logic                      win_valid;
  logic [NUM_REQ-1:0]        eligible;
  logic [NUM_REQ-1:0]        ack_nxt, err_nxt;
  logic                      start_nxt, busy_nxt;
  logic [DATA_DFX_WIDTH-1:0] data_nxt;
  logic [15:0]               frame_nxt;
  logic                      accept, done_ok, timeout;

  // Encoder handshake: a start is consumed on the first edge where start_encode_pkt and
  // ready_encode_pkt are both high; encode_done is a single-cycle pulse honoured only in WAIT_DONE.
  assign accept  = (state == START) && ready_encode_pkt;
  assign done_ok = (state == WAIT_DONE) && encode_done;
  assign timeout = (state != IDLE) && (tcnt >= TCNT_W'(TIMEOUT_CYCLES - 1)) && !accept && !done_ok;

  // The source being acked this cycle is masked so a lingering req cannot win again at once.
  assign eligible = req & ~req_ack;

  always_comb begin : rr_search
    int idx;
    idx       = 0;
    win_valid = 1'b0;
    winner    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!win_valid && eligible[idx]) begin
        win_valid = 1'b1;
        winner    = ID_WIDTH'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin : next_state
    state_nxt = state;
    case (state)
      IDLE:      if (win_valid && ready_encode_pkt) state_nxt = START;
      START:     if (accept) state_nxt = WAIT_DONE;
                 else if (timeout) state_nxt = IDLE;
      WAIT_DONE: if (done_ok || timeout) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin : output_logic
    start_nxt = start_encode_pkt;
    ack_nxt   = '0;
    err_nxt   = '0;
    data_nxt  = data_dfx_send;
    grant_nxt = grant_id;
    last_nxt  = last_grant;
    frame_nxt = frame_cnt;
    tcnt_nxt  = tcnt;
    case (state)
      IDLE: begin
        if (win_valid && ready_encode_pkt) begin
          grant_nxt = winner;
          data_nxt  = req_data[winner*DATA_DFX_WIDTH +: DATA_DFX_WIDTH];
          start_nxt = 1'b1;
          tcnt_nxt  = '0;
        end
      end
      START, WAIT_DONE: begin
        tcnt_nxt = tcnt + TCNT_W'(1);
        if (accept) start_nxt = 1'b0;
        if (done_ok) begin
          ack_nxt[grant_id] = 1'b1;
          last_nxt          = grant_id;
          frame_nxt         = frame_cnt + 16'd1;
        end else if (timeout) begin
          ack_nxt[grant_id] = 1'b1;
          err_nxt[grant_id] = 1'b1;
          start_nxt         = 1'b0;
          last_nxt          = grant_id;
        end
      end
      default: start_nxt = 1'b0;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin : datapath_reg
    if (!rst_n) begin
      start_encode_pkt <= 1'b0;
      req_ack          <= '0;
      req_err          <= '0;
      busy             <= 1'b0;
      data_dfx_send    <= '0;
      grant_id         <= '0;
      last_grant       <= ID_WIDTH'(NUM_REQ - 1);
      frame_cnt        <= '0;
      tcnt             <= '0;
    end else begin
      start_encode_pkt <= start_nxt;
      req_ack          <= ack_nxt;
      req_err          <= err_nxt;
      busy             <= busy_nxt;
      data_dfx_send    <= data_nxt;
      grant_id         <= grant_nxt;
      last_grant       <= last_nxt;
      frame_cnt        <= frame_nxt;
      tcnt             <= tcnt_nxt;
    end
  end

  assign active_id = grant_id;

endmodule

// File: tb/tb_encode_arbiter.sv
// Randomized bench for encode_arbiter: bench-driven sources and encoder, with a
// transaction-level model predicting winner, ack cycle, error flag and frame count.
module tb_encode_arbiter;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
  localparam int DW      = 1034;
  localparam int T       = 64;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_REQ-1:0]     req = '0;
  logic [NUM_REQ*DW-1:0]  req_data = '0;
  logic [NUM_REQ-1:0]     req_ack, req_err;
  logic                   start_encode_pkt;
  logic [DW-1:0]          data_dfx_send;
  logic                   ready_encode_pkt = 1'b0;
  logic                   encode_done = 1'b0;
  logic                   busy;
  logic [IDW-1:0]         active_id;
  logic [15:0]            frame_cnt;

  encode_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(IDW), .DATA_DFX_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_ack(req_ack), .req_err(req_err),
    .start_encode_pkt(start_encode_pkt), .data_dfx_send(data_dfx_send),
    .ready_encode_pkt(ready_encode_pkt), .encode_done(encode_done), .busy(busy),
    .active_id(active_id), .frame_cnt(frame_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  int          last_grant = NUM_REQ - 1;
  int          frame = 0;
  int          acked = -1;
  bit          pending[NUM_REQ];
  logic [DW-1:0] src_data[NUM_REQ];
  logic [NUM_REQ-1:0] drop_mask = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  // XOR-fold to 64 bits; any single-bit difference changes the signature
  function automatic logic [63:0] fold(input logic [DW-1:0] w);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < DW; i++) s[i % 64] = s[i % 64] ^ w[i];
    return s;
  endfunction

  function automatic int rr_pick(input logic [NUM_REQ-1:0] elig);
    for (int k = 1; k <= NUM_REQ; k++)
      if (elig[(last_grant + k) % NUM_REQ]) return (last_grant + k) % NUM_REQ;
    return -1;
  endfunction

  // driver tasks
  task automatic drive_req();
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i] = pending[i] && !drop_mask[i];
      req_data[i*DW +: DW] = src_data[i];
    end
  endtask

  // mode 0: every idle source requests, 1: random refill, 2: only source 0
  task automatic run_txn(input int mode, input int stall, input int done_k, input bit drop_after);
    logic [NUM_REQ-1:0] elig;
    int win, exp_k, j;
    bit exp_err, got_ack;
    logic [63:0] onehot, exp_id;
    for (int i = 0; i < NUM_REQ; i++)
      if (!pending[i] && (mode == 0 || (mode == 1 && $urandom_range(0, 1) == 1) || (mode == 2 && i == 0))) begin
        pending[i]  = 1'b1;
        src_data[i] = rand_word();
      end
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) elig[i] = pending[i] && (i != acked);
    if (elig == '0) begin
      j = $urandom_range(0, NUM_REQ - 1);
      if (j == acked) j = (j + 1) % NUM_REQ;
      pending[j]  = 1'b1;
      src_data[j] = rand_word();
      elig[j]     = 1'b1;
    end
    drop_mask = '0;
    drive_req();
    ready_encode_pkt = 1'b1;
    encode_done      = 1'b0;
    win = rr_pick(elig);
    exp_q.push_back(64'(win));
    @(posedge clk); @(negedge clk);
    acked  = -1;
    exp_id = exp_q.pop_front();
    check_eq("grant_start", 64'(start_encode_pkt), 64'd1);
    check_eq("grant_busy", 64'(busy), 64'd1);
    check_eq("grant_id", 64'(active_id), exp_id);
    check_eq("grant_data", fold(data_dfx_send), fold(src_data[win]));
    if (drop_after) drop_mask[win] = 1'b1;
    drive_req();
    exp_err = (done_k == 0) || (done_k > T);
    exp_k   = exp_err ? T : done_k;
    onehot  = 64'd1 << win;
    got_ack = 1'b0;
    for (int k = 1; k <= T + 2 && !got_ack; k++) begin
      ready_encode_pkt = (k > stall);
      encode_done      = (k == done_k);
      @(posedge clk); @(negedge clk);
      encode_done = 1'b0;
      if (k == stall) check_eq("start_held", 64'(start_encode_pkt), 64'd1);
      if (k == stall + 1) check_eq("start_drop", 64'(start_encode_pkt), 64'd0);
      if (req_ack != '0) begin
        got_ack = 1'b1;
        if (!exp_err) frame = (frame + 1) & 16'hffff;
        check_eq("ack_cycle", 64'(k), 64'(exp_k));
        check_eq("req_ack", 64'(req_ack), onehot);
        check_eq("req_err", 64'(req_err), exp_err ? onehot : 64'd0);
        check_eq("end_busy", 64'(busy), 64'd0);
        check_eq("frame_cnt", 64'(frame_cnt), 64'(frame));
        check_eq("data_hold", fold(data_dfx_send), fold(src_data[win]));
      end
    end
    if (!got_ack) begin
      check_eq("ack_missing", 64'(req_ack), onehot);
      if (!exp_err) frame = (frame + 1) & 16'hffff;
    end
    last_grant   = win;
    pending[win] = 1'b0;
    drop_mask    = '0;
    acked        = win;
    drive_req();
    if (exp_err) begin
      // a done pulse while idle must be ignored
      ready_encode_pkt = 1'b0;
      encode_done      = 1'b1;
      @(posedge clk); @(negedge clk);
      encode_done = 1'b0;
      check_eq("idle_done_ack", 64'(req_ack), 64'd0);
      check_eq("idle_done_frame", 64'(frame_cnt), 64'(frame));
      check_eq("idle_done_busy", 64'(busy), 64'd0);
      acked = -1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_start"}, 64'(start_encode_pkt), 64'd0);
    check_eq({tag, "_ack"}, 64'(req_ack), 64'd0);
    check_eq({tag, "_err"}, 64'(req_err), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_id"}, 64'(active_id), 64'd0);
    check_eq({tag, "_frame"}, 64'(frame_cnt), 64'd0);
    check_eq({tag, "_data"}, fold(data_dfx_send), 64'd0);
  endtask

  initial begin
    int stall, done_k, sel;
    for (int i = 0; i < NUM_REQ; i++) begin
      pending[i]  = 1'b0;
      src_data[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // contention from reset: order 0,1,2,3,0
    for (int t = 0; t < 5; t++) run_txn(0, 0, 22, 1'b0);
    check_eq("contention_frames", 64'(frame_cnt), 64'd5);

    run_txn(1, 5, 6 + 21, 1'b0);   // ready stall in START
    run_txn(1, 0, 0, 1'b0);        // encoder never finishes
    run_txn(1, 0, T, 1'b0);        // done on the timeout edge
    run_txn(1, 2, T + 1, 1'b1);    // done too late, req dropped after grant

    for (int t = 0; t < 20; t++) begin
      stall = $urandom_range(0, 6);
      sel   = $urandom_range(0, 5);
      case (sel)
        0:       done_k = 0;
        1:       done_k = T;
        2:       done_k = T + 1;
        default: done_k = stall + 1 + $urandom_range(1, 40);
      endcase
      run_txn(1, stall, done_k, 1'($urandom_range(0, 1)));
    end

    // reset while waiting for done
    for (int i = 0; i < NUM_REQ; i++) begin
      pending[i]  = 1'b1;
      src_data[i] = rand_word();
    end
    drive_req();
    ready_encode_pkt = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    last_grant = NUM_REQ - 1;
    frame      = 0;
    acked      = -1;
    for (int i = 0; i < NUM_REQ; i++) pending[i] = 1'b0;
    ready_encode_pkt = 1'b0;
    drive_req();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(0, 0, 22, 1'b0);       // all request; source 0 must win

    // single request after a fresh reset
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) pending[i] = 1'b0;
    last_grant = NUM_REQ - 1;
    frame      = 0;
    acked      = -1;
    drive_req();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(2, 0, 22, 1'b0);
    check_eq("single_frames", 64'(frame_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
